// File: rtl/noise_stage_controller.sv
// noise_stage_controller
// Noise-detection stage of a switching median filter. It takes one 3x3 window
// at a time and flags salt/pepper pixels. A clean centre pixel passes straight
// through. A noisy centre goes to the external median unit, and an all-noisy
// window reuses the last pixel that was sent downstream.
module noise_stage_controller #(
    parameter int DW         = 8,
    parameter int SALT_VAL   = 255,
    parameter int PEPPER_VAL = 0,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    X0,
    input  logic [DW-1:0]    X1,
    input  logic [DW-1:0]    X2,
    input  logic [DW-1:0]    X3,
    input  logic [DW-1:0]    X4,
    input  logic [DW-1:0]    X5,
    input  logic [DW-1:0]    X6,
    input  logic [DW-1:0]    X7,
    input  logic [DW-1:0]    X8,
    output logic             med_valid,
    input  logic             med_ready,
    output logic [8:0]       med_mask,
    input  logic             med_done,
    input  logic [DW-1:0]    med_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_pixel,
    output logic             out_filt,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] noisy_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DETECT   = 3'd1;
    localparam logic [2:0] MED_REQ  = 3'd2;
    localparam logic [2:0] MED_WAIT = 3'd3;
    localparam logic [2:0] OUT      = 3'd4;

    localparam logic [DW-1:0] SALT_C   = DW'(SALT_VAL);
    localparam logic [DW-1:0] PEPPER_C = DW'(PEPPER_VAL);

    logic [2:0]       state_q, state_d;
    logic [DW-1:0]    win_q [9];
    logic [DW-1:0]    xIn [9];
    logic             loadWin;
    logic [8:0]       mask;
    logic [8:0]       mask_q, mask_d;
    logic [DW-1:0]    pix_q, pix_d;
    logic             filt_q, filt_d;
    logic [DW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign xIn[0] = X0;
    assign xIn[1] = X1;
    assign xIn[2] = X2;
    assign xIn[3] = X3;
    assign xIn[4] = X4;
    assign xIn[5] = X5;
    assign xIn[6] = X6;
    assign xIn[7] = X7;
    assign xIn[8] = X8;

    // Handshake outputs are pure state decodes, so no input reaches them combinationally.
    assign in_ready  = (state_q == IDLE);
    assign med_valid = (state_q == MED_REQ);
    assign out_valid = (state_q == OUT);
    assign med_mask  = mask_q;
    assign out_pixel = pix_q;
    assign out_filt  = filt_q;
    assign noisy_cnt = cnt_q;

    // Noise mask of the captured window: a pixel is noisy if it holds a salt or pepper code.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 9; i++) begin
            mask[i] = (win_q[i] == SALT_C) || (win_q[i] == PEPPER_C);
        end
    end

    // Next-state and datapath decisions for the window sequencer.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pix_d   = pix_q;
        filt_d  = filt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        loadWin = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    loadWin = 1'b1;
                    state_d = DETECT;
                end
            end
            DETECT: begin
                if (!mask[4]) begin
                    pix_d   = win_q[4];
                    filt_d  = 1'b0;
                    state_d = OUT;
                end else if (mask == 9'h1FF) begin
                    pix_d   = last_q;
                    filt_d  = 1'b1;
                    state_d = OUT;
                end else begin
                    mask_d  = mask;
                    state_d = MED_REQ;
                end
                if (mask[4] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MED_REQ: begin
                if (med_ready) begin
                    state_d = MED_WAIT;
                end
            end
            MED_WAIT: begin
                if (med_done) begin
                    pix_d   = med_result;
                    filt_d  = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    last_d  = pix_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear has priority over an increment in the same cycle.
        if (stat_clr) begin
            cnt_d = '0;
        end
    end

    // Control and result registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pix_q   <= '0;
            filt_q  <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pix_q   <= pix_d;
            filt_q  <= filt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Window capture on an accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (loadWin) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= xIn[i];
            end
        end
    end

endmodule

// File: tb/tb_noise_stage_controller.sv
// Testbench for noise_stage_controller. It runs directed windows and then
// randomized ones, using a scoreboard queue, a behavioural window model and a
// modelled median unit.
module tb_noise_stage_controller;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] X [9];
    logic          med_valid;
    logic          med_ready = 1'b0;
    logic [8:0]    med_mask;
    logic          med_done = 1'b0;
    logic [DW-1:0] med_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_pixel;
    logic          out_filt;
    logic          stat_clr = 1'b0;
    logic [CW-1:0] noisy_cnt;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;
    int reqCount = 0;
    int lastHsCycle = 0;
    int acceptCycle = 0;

    // bench control knobs
    bit holdLow = 0;
    bit randSink = 0;
    bit holdDone = 0;
    bit spurEnable = 0;
    int medDelay = 0;
    int medHoldMax = 0;

    // reference model state
    logic [DW-1:0] curWin [9];
    logic [DW:0]   expQ [$];
    logic [DW-1:0] medQ [$];
    logic [8:0]    maskQ [$];
    logic [DW-1:0] lastModel = '0;
    int            cntModel = 0;

    noise_stage_controller #(.DW(DW), .SALT_VAL(255), .PEPPER_VAL(0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X0(X[0]), .X1(X[1]), .X2(X[2]), .X3(X[3]), .X4(X[4]),
        .X5(X[5]), .X6(X[6]), .X7(X[7]), .X8(X[8]),
        .med_valid(med_valid), .med_ready(med_ready), .med_mask(med_mask),
        .med_done(med_done), .med_result(med_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_filt(out_filt), .stat_clr(stat_clr), .noisy_cnt(noisy_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Behavioural model: classify the window and work out what the stage should emit.
    task automatic modelWindow();
        logic [8:0]    m;
        logic [DW-1:0] clean [$];
        logic [DW-1:0] pix;
        logic          filt;
        m = '0;
        for (int i = 0; i < 9; i++) begin
            if (curWin[i] == 8'd255 || curWin[i] == 8'd0) m[i] = 1'b1;
            else clean.push_back(curWin[i]);
        end
        if (!m[4]) begin
            pix = curWin[4];
            filt = 1'b0;
        end else if (clean.size() == 0) begin
            pix = lastModel;
            filt = 1'b1;
        end else begin
            clean.sort();
            pix = clean[(clean.size() - 1) / 2];
            filt = 1'b1;
            medQ.push_back(pix);
            maskQ.push_back(m);
        end
        if (m[4]) cntModel = (cntModel == 3) ? 3 : cntModel + 1;
        lastModel = pix;
        expQ.push_back({filt, pix});
    endtask

    // Present curWin until the controller accepts it, then log the expectation.
    task automatic applyStimulus();
        bit acc;
        int n;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) X[i] = curWin[i];
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) timeoutFail("accept");
        else begin
            acceptCycle = cycle;
            modelWindow();
        end
    endtask

    task automatic setWin(input logic [DW-1:0] centre, input logic [DW-1:0] others);
        for (int i = 0; i < 9; i++) curWin[i] = others;
        curWin[4] = centre;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeoutFail("drain");
    endtask

    // Downstream sink: ready is always, randomly, or never asserted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = holdLow ? 1'b0 : (randSink ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pop the scoreboard on every output handshake.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                lastHsCycle = cycle;
                if (expQ.size() == 0) checkOutput("unexpected_out", 1, 0);
                else begin
                    e = expQ.pop_front();
                    checkOutput("out_pixel", out_pixel, e[DW-1:0]);
                    checkOutput("out_filt", out_filt, e[DW]);
                end
            end
        end
    end

    // Median unit model: accept requests, check the mask, return the model median.
    initial begin
        logic [DW-1:0] res;
        bit spur;
        forever begin
            @(negedge clk);
            if (!rst && med_valid) begin
                repeat ($urandom_range(0, medHoldMax)) @(negedge clk);
                med_ready = 1'b1;
                reqCount++;
                if (maskQ.size() == 0) checkOutput("unexpected_med_req", 1, 0);
                else checkOutput("med_mask", med_mask, maskQ.pop_front());
                res = (medQ.size() != 0) ? medQ.pop_front() : '0;
                spur = spurEnable && ($urandom_range(0, 1) == 1);
                if (spur) begin
                    med_done = 1'b1;
                    med_result = ~res;
                end
                @(negedge clk);
                med_ready = 1'b0;
                med_done = 1'b0;
                if (!holdDone) begin
                    repeat ((medDelay < 0) ? $urandom_range(0, 4) : medDelay) @(negedge clk);
                    med_done = 1'b1;
                    med_result = res;
                    @(negedge clk);
                    med_done = 1'b0;
                end
            end
        end
    end

    // Main sequence: directed cases first, then random traffic, then reset recovery.
    initial begin
        int savedReq;
        int n;
        for (int i = 0; i < 9; i++) X[i] = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_med_valid", med_valid, 0);
        checkOutput("rst_med_mask", med_mask, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_pixel", out_pixel, 0);
        checkOutput("rst_out_filt", out_filt, 0);
        checkOutput("rst_noisy_cnt", noisy_cnt, 0);
        rst = 1'b0;

        // noisy centre goes through the median unit
        medDelay = 2;
        setWin(8'd255, 8'd50);
        applyStimulus();
        waitDrain();
        checkOutput("t2_noisy_cnt", noisy_cnt, 1);

        // clean window passes through with 2-cycle latency
        setWin(8'd100, 8'd100);
        applyStimulus();
        @(negedge clk);
        checkOutput("t1_lat_c1", out_valid, 0);
        @(negedge clk);
        checkOutput("t1_lat_c2", out_valid, 1);
        waitDrain();
        checkOutput("t1_noisy_cnt", noisy_cnt, 1);

        // all-noisy window reuses the last output pixel
        savedReq = reqCount;
        for (int i = 0; i < 9; i++) curWin[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        applyStimulus();
        waitDrain();
        checkOutput("t3_no_med_req", reqCount, savedReq);
        checkOutput("t3_last_pix_used", lastModel, 100);

        // output stall keeps data steady and blocks new windows
        holdLow = 1;
        setWin(8'd77, 8'd10);
        applyStimulus();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        setWin(8'd88, 8'd20);
        for (int i = 0; i < 9; i++) X[i] = curWin[i];
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t4_out_valid_held", out_valid, 1);
            checkOutput("t4_out_pixel_held", out_pixel, 77);
            checkOutput("t4_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        holdLow = 0;
        applyStimulus();
        checkOutput("t4_accept_after_hs", (acceptCycle > lastHsCycle), 1);
        waitDrain();

        // counter saturation and clear priority
        medDelay = -1;
        for (int k = 0; k < 5; k++) begin
            setWin(8'd0, 8'd30 + 8'(k));
            applyStimulus();
            waitDrain();
        end
        checkOutput("t5_cnt_saturated", noisy_cnt, 3);
        setWin(8'd255, 8'd40);
        applyStimulus();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        cntModel = 0;
        waitDrain();
        checkOutput("t5_clr_wins", noisy_cnt, 0);

        // randomized traffic with stalls and stray med_done pulses
        randSink = 1;
        spurEnable = 1;
        medHoldMax = 2;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < 9; i++) curWin[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            end else begin
                for (int i = 0; i < 9; i++) begin
                    if ($urandom_range(0, 3) == 0) curWin[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
                    else curWin[i] = 8'($urandom_range(1, 254));
                end
            end
            applyStimulus();
        end
        waitDrain();
        checkOutput("rand_noisy_cnt", noisy_cnt, cntModel);
        randSink = 0;
        spurEnable = 0;
        medHoldMax = 0;

        // reset while waiting for the median result
        holdDone = 1;
        savedReq = reqCount;
        setWin(8'd255, 8'd60);
        applyStimulus();
        n = 0;
        while (reqCount == savedReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeoutFail("t6_med_req");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_in_ready", in_ready, 1);
        checkOutput("t6_med_valid", med_valid, 0);
        checkOutput("t6_med_mask", med_mask, 0);
        checkOutput("t6_out_valid", out_valid, 0);
        checkOutput("t6_out_pixel", out_pixel, 0);
        checkOutput("t6_out_filt", out_filt, 0);
        checkOutput("t6_noisy_cnt", noisy_cnt, 0);
        expQ.delete();
        medQ.delete();
        maskQ.delete();
        lastModel = '0;
        cntModel = 0;
        holdDone = 0;
        rst = 1'b0;
        @(negedge clk);
        setWin(8'd123, 8'd5);
        applyStimulus();
        waitDrain();
        checkOutput("t6_after_cnt", noisy_cnt, 0);
        for (int i = 0; i < 9; i++) curWin[i] = 8'd255;
        applyStimulus();
        waitDrain();
        checkOutput("t6_after_last_pix", lastModel, 123);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
